// File: rtl/fetch_redirect_unit.sv
// Instruction-fetch front end: owns the fetch PC, runs the instruction-memory
// read handshake, buffers fetched words for decode and restarts fetch at the
// resolved target when a taken branch/jump redirects the stream.
// Optional build macro FETCH_MISALIGN_TRAP_EN: misaligned redirect targets
// raise target_misaligned and park the unit in HALT instead of having their
// low two bits cleared.

package branch_decoder_unit_pkg;
  typedef enum logic {
    PcPlus4             = 1'b0,
    PcOrReadDataPlusImm = 1'b1
  } pc_src_t;
endpackage

module fetch_redirect_unit
  import branch_decoder_unit_pkg::*;
#(
  parameter int               Width       = 32,
  parameter logic [Width-1:0] ResetVector = '0,
  parameter int               BufferDepth = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             redirect_valid,
  input  pc_src_t          pc_src,
  input  logic [Width-1:0] branch_target,
  output logic             mem_rd_en,
  output logic [Width-1:0] mem_addr,
  input  logic             mem_ack,
  input  logic [Width-1:0] mem_rd_data,
  output logic             inst_valid,
  input  logic             inst_ready,
  output logic [Width-1:0] inst,
  output logic [Width-1:0] inst_pc
`ifdef FETCH_MISALIGN_TRAP_EN
  ,
  output logic             target_misaligned
`endif
);

  localparam int            PtrW = $clog2(BufferDepth);
  localparam logic [PtrW:0] Full = (PtrW + 1)'(BufferDepth);

  typedef enum logic [1:0] {
    S_FETCH,
    S_STALL,
    S_DRAIN,
    S_HALT
  } state_t;

  state_t           state_q, state_d;
  logic [Width-1:0] pc_q, pc_d;
  logic [Width-1:0] addr_q, addr_d;
  logic             rd_en_q, rd_en_d;
  logic             misaligned_q, misaligned_d;
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PtrW:0]    count_q, count_d;

  logic [Width-1:0] data_mem [BufferDepth];
  logic [Width-1:0] pc_mem   [BufferDepth];

  logic             redirect;
  logic             accept;
  logic             push;
  logic             pop;
  logic             bad_target;
  logic [Width-1:0] target;

  // A taken redirect cancels any push or pop that would otherwise happen this cycle.
  assign redirect = redirect_valid && (pc_src == PcOrReadDataPlusImm);
  assign accept   = rd_en_q && mem_ack;
  assign push     = accept && (state_q == S_FETCH) && !redirect;
  assign pop      = (count_q != '0) && inst_ready && !redirect;

`ifdef FETCH_MISALIGN_TRAP_EN
  assign target            = branch_target;
  assign bad_target        = (branch_target[1:0] != 2'b00);
  assign target_misaligned = misaligned_q;
`else
  logic unused_target_bits;
  assign target             = {branch_target[Width-1:2], 2'b00};
  assign bad_target         = 1'b0;
  assign unused_target_bits = ^branch_target[1:0];
`endif

  assign mem_rd_en  = rd_en_q;
  assign mem_addr   = addr_q;
  assign inst_valid = (count_q != '0);
  assign inst       = data_mem[rd_ptr_q];
  assign inst_pc    = pc_mem[rd_ptr_q];

  // Buffer occupancy and pointers; a redirect empties the buffer outright.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (redirect) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      count_d = count_q + (PtrW + 1)'(push) - (PtrW + 1)'(pop);
    end
  end

  // Fetch sequencing: next state, PC and the registered request outputs.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    misaligned_d = misaligned_q;
    case (state_q)
      S_FETCH: begin
        if (accept) pc_d = pc_q + Width'(4);
        // Only a push can fill the buffer, so no request is open when stalling.
        if (count_d == Full) state_d = S_STALL;
      end
      S_STALL: if (pop) state_d = S_FETCH;
      // The outstanding word is dropped; pc already holds the redirect target.
      S_DRAIN: if (accept) state_d = misaligned_q ? S_HALT : S_FETCH;
      default: ;
    endcase
    if (redirect) begin
      pc_d         = target;
      misaligned_d = bad_target;
      if (rd_en_q && !mem_ack) state_d = S_DRAIN;
      else                     state_d = bad_target ? S_HALT : S_FETCH;
    end
    rd_en_d = (state_d == S_FETCH) || (state_d == S_DRAIN);
    // While draining the old request address must stay on the bus until ack.
    addr_d  = (state_d == S_DRAIN) ? addr_q : pc_d;
  end

  // Control and pointer registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= S_FETCH;
      pc_q         <= ResetVector;
      addr_q       <= ResetVector;
      rd_en_q      <= 1'b0;
      misaligned_q <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      addr_q       <= addr_d;
      rd_en_q      <= rd_en_d;
      misaligned_q <= misaligned_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
    end
  end

  // Buffer storage; occupancy gates inst_valid so the contents need no reset.
  always_ff @(posedge clock) begin
    if (push) begin
      data_mem[wr_ptr_q] <= mem_rd_data;
      pc_mem[wr_ptr_q]   <= addr_q;
    end
  end

endmodule
